memory_stage: RTL
=================

Name: memory_stage

Overview:
- Pipeline MEM stage, directly downstream of execute; consumes the REG_EX_MEM register and produces REG_MEM_WB for writeback.
- Issues at most one load/store per instruction on the data bus and waits for the response.
- Aligns store data and byte strobes, then extracts and sign/zero-extends load data.
- Stalls the pipeline via ok_to_proceed and publishes a forwarding source for decode.

Parameters:
- DBUS_W, 64, data bus width in bits. Only 64 is supported.
- CHECK_ALIGN, 1, when 1, misaligned accesses are detected and suppressed.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- moduleIn  in  REG_EX_MEM  from execute: valid, rs2, aluOut (address/result), wd, isWriteBack, isMemRead, isMemWrite, memMode, instrAddr, instr, pcPlus4.
- moduleOut  out  REG_MEM_WB  registered: valid, wd, isWriteBack, wbData, instrAddr, instr, memAddr, isMem, misalign.
- forwardSource  out  FORWARD_SOURCE  {valid, isWb, wd, wdData}.
- fwd_pending  out  1  wd's data is a load not yet returned; decode must stall.
- ok_to_proceed  out  1  this stage can advance.
- ok_to_proceed_overall  in  1  global advance enable; AND of all stages.
- dreq_valid  out  1  data bus request.
- dreq_addr  out  64  byte address (aluOut).
- dreq_write  out  1  1 = store.
- dreq_size  out  3  memMode[1:0] zero-extended: 0=B, 1=H, 2=W, 3=D.
- dreq_strobe  out  8  byte-write enables; 0 for loads.
- dreq_data  out  64  lane-aligned store data.
- dresp_data_ok  in  1  response valid for the outstanding request.
- dresp_data  in  64  raw 64-bit aligned load data.

Behaviour:
- A memory operation (memop) is moduleIn.valid & (isMemRead | isMemWrite).
- Misalign is set when CHECK_ALIGN is 1 and the address is not aligned: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - dreq_valid = memop & ~misalign.
  - On dresp_data_ok in the same cycle, go to DONE and capture data.
  - Otherwise, if dreq_valid, go to REQ.
  - A misaligned memop goes directly to DONE with no bus request.
- REQ: dreq_valid=1, with all dreq fields held from moduleIn, which is stable because this stage stalls. On dresp_data_ok, capture dresp_data and go to DONE.
- DONE: dreq_valid=0. On ok_to_proceed_overall, go to IDLE. The same instruction is never re-issued.
- ok_to_proceed = ~memop | (state==DONE).
  - Non-memory instructions pass through with zero added latency.
  - Memory instructions take at least 1 stall cycle (IDLE→DONE).
- dresp_data_ok in IDLE with no request outstanding is ignored.
- Store alignment, with sh = 8*addr[2:0]:
  - dreq_data = rs2 << sh.
  - dreq_strobe = (B:0x01, H:0x03, W:0x0F, D:0xFF) << addr[2:0].
- Load extraction:
  - raw = captured data >> sh.
  - memMode[2]=0 sign-extends from bit 7/15/31; memMode[2]=1 zero-extends. D is taken unmodified.
- wbData is the extracted load data for loads and moduleIn.aluOut otherwise; stores do not write back.
- Output register, on ok_to_proceed_overall:
  - moduleOut.valid <= moduleIn.valid.
  - All other fields copied.
  - memAddr <= aluOut.
  - isMem <= isMemRead|isMemWrite.
  - misalign <= misalign.
  - Without ok_to_proceed_overall, moduleOut holds.
- forwardSource:
  - valid = moduleIn.valid & wd!=0.
  - isWb = isWriteBack.
  - wd = moduleIn.wd.
  - wdData = wbData.
- fwd_pending = moduleIn.valid & isMemRead & (state!=DONE).
- Reset (rst=0), asynchronous:
  - state=IDLE, moduleOut.valid=0, all other moduleOut fields 0, captured data 0.
  - dreq_valid is forced 0 while rst=0.
  - A response arriving after reset is released is ignored.

Decomposition:
- common package holds:
  - REG_MEM_WB: new fields wbData, memAddr, isMem, misalign.
  - FORWARD_SOURCE, unchanged.
  - memMode encoding constants MEM_B/H/W/D and MEM_UNSIGNED.
  - mem_state_t enum.
- One sub-module is natural: mem_align. It is purely combinational and produces strobe, shifted store data and extended load data from (memMode, addr[2:0], rs2, raw).

Test Plan:
- LD at 0x80001000, dresp after 3 wait cycles returns 0x1122334455667788:
  - ok_to_proceed=0 for 4 cycles.
  - wbData=0x1122334455667788.
  - dreq_valid held high with a constant address.
- LB at 0x...03 with dresp 0x00000000_80FF7F00 → wbData=0xFFFFFFFFFFFFFF80. LBU of the same access → 0x80.
- SH rs2=0xABCD at addr 0x...06 → strobe=0xC0, dreq_data=0xABCD000000000000, isWriteBack ignored, moduleOut.valid=1.
- Load completes while ok_to_proceed_overall is held 0 for 5 cycles:
  - State stays DONE, no second request, fwd_pending=0.
  - moduleOut updates once on release.
- Back-to-back add (aluOut=42) then LW with 0-wait response:
  - add passes with ok_to_proceed=1 and wbData=42.
  - LW stalls exactly 1 cycle.
- Reset (rst=0) asserted in REQ: dreq_valid=0 immediately, moduleOut.valid=0. A subsequent stray dresp_data_ok is ignored. LW at addr 0x...02 → misalign=1, no request.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared pipeline register types and memory access encodings
package memory_stage_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;
  localparam logic [2:0] MEM_UNSIGNED = 3'b100;

  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] rs2;
    logic [63:0] aluOut;
    logic [4:0]  wd;
    logic        isWriteBack;
    logic        isMemRead;
    logic        isMemWrite;
    logic [2:0]  memMode;
    logic [63:0] instrAddr;
    logic [31:0] instr;
    logic [63:0] pcPlus4;
  } REG_EX_MEM;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wd;
    logic        isWriteBack;
    logic [63:0] wbData;
    logic [63:0] instrAddr;
    logic [31:0] instr;
    logic [63:0] memAddr;
    logic        isMem;
    logic        misalign;
  } REG_MEM_WB;

  typedef struct packed {
    logic        valid;
    logic        isWb;
    logic [4:0]  wd;
    logic [63:0] wdData;
  } FORWARD_SOURCE;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr);
    case (size)
      MEM_H:   return addr[0];
      MEM_W:   return |addr[1:0];
      MEM_D:   return |addr;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// rtl/memory_stage_mem_align.sv - byte-lane alignment of store data/strobes and load extraction
module mem_align
  import memory_stage_pkg::*;
(
  input  logic [2:0]  i_mode,
  input  logic [2:0]  i_addr,
  input  logic [63:0] i_rs2,
  input  logic [63:0] i_raw,
  output logic [7:0]  o_strobe,
  output logic [63:0] o_st_data,
  output logic [63:0] o_ld_data
);

  logic [5:0]  w_sh;
  logic [63:0] w_raw;
  logic        w_sx;

  assign w_sh      = {i_addr, 3'b000};
  assign o_st_data = i_rs2 << w_sh;
  assign w_raw     = i_raw >> w_sh;
  assign w_sx      = ~i_mode[2];

  always_comb begin
    o_strobe  = 8'hFF << i_addr;
    o_ld_data = w_raw;
    case (i_mode[1:0])
      MEM_B: begin
        o_strobe  = 8'h01 << i_addr;
        o_ld_data = {{56{w_sx & w_raw[7]}}, w_raw[7:0]};
      end
      MEM_H: begin
        o_strobe  = 8'h03 << i_addr;
        o_ld_data = {{48{w_sx & w_raw[15]}}, w_raw[15:0]};
      end
      MEM_W: begin
        o_strobe  = 8'h0F << i_addr;
        o_ld_data = {{32{w_sx & w_raw[31]}}, w_raw[31:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline MEM stage: single-issue data bus access, stall and forwarding
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DBUS_W      = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  REG_EX_MEM             moduleIn,
  output REG_MEM_WB             moduleOut,
  output FORWARD_SOURCE         forwardSource,
  output logic                  fwd_pending,
  output logic                  ok_to_proceed,
  input  logic                  ok_to_proceed_overall,
  output logic                  dreq_valid,
  output logic [63:0]           dreq_addr,
  output logic                  dreq_write,
  output logic [2:0]            dreq_size,
  output logic [DBUS_W/8-1:0]   dreq_strobe,
  output logic [DBUS_W-1:0]     dreq_data,
  input  logic                  dresp_data_ok,
  input  logic [DBUS_W-1:0]     dresp_data
);

  mem_state_t  r_state;
  logic [63:0] r_data;
  logic        w_memop;
  logic        w_misalign;
  logic [7:0]  w_strobe;
  logic [63:0] w_st_data;
  logic [63:0] w_ld_data;
  logic [63:0] w_wb_data;
  logic        w_unused;

  assign w_memop    = moduleIn.valid & (moduleIn.isMemRead | moduleIn.isMemWrite);
  assign w_misalign = CHECK_ALIGN & w_memop
                    & is_misaligned(moduleIn.memMode[1:0], moduleIn.aluOut[2:0]);

  mem_align u_align (
    .i_mode   (moduleIn.memMode),
    .i_addr   (moduleIn.aluOut[2:0]),
    .i_rs2    (moduleIn.rs2),
    .i_raw    (r_data),
    .o_strobe (w_strobe),
    .o_st_data(w_st_data),
    .o_ld_data(w_ld_data)
  );

  // Held in reset, the bus must see no request even while a memop sits at the input.
  assign dreq_valid  = rst & (((r_state == IDLE) & w_memop & ~w_misalign) | (r_state == REQ));
  assign dreq_addr   = moduleIn.aluOut;
  assign dreq_write  = moduleIn.isMemWrite;
  assign dreq_size   = {1'b0, moduleIn.memMode[1:0]};
  assign dreq_strobe = moduleIn.isMemWrite ? w_strobe : 8'h00;
  assign dreq_data   = w_st_data;

  assign ok_to_proceed = ~w_memop | (r_state == DONE);
  assign fwd_pending   = moduleIn.valid & moduleIn.isMemRead & (r_state != DONE);
  assign w_wb_data     = moduleIn.isMemRead ? w_ld_data : moduleIn.aluOut;

  assign forwardSource.valid  = moduleIn.valid & (moduleIn.wd != 5'd0);
  assign forwardSource.isWb   = moduleIn.isWriteBack;
  assign forwardSource.wd     = moduleIn.wd;
  assign forwardSource.wdData = w_wb_data;

  assign w_unused = ^moduleIn.pcPlus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_memop) begin
          if (w_misalign) begin
            r_state <= DONE;
          end else if (dresp_data_ok) begin
            r_data  <= dresp_data;
            r_state <= DONE;
          end else begin
            r_state <= REQ;
          end
        end
        REQ: if (dresp_data_ok) begin
          r_data  <= dresp_data;
          r_state <= DONE;
        end
        DONE: if (ok_to_proceed_overall) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      moduleOut <= '0;
    end else if (ok_to_proceed_overall) begin
      moduleOut.valid       <= moduleIn.valid;
      moduleOut.wd          <= moduleIn.wd;
      moduleOut.isWriteBack <= moduleIn.isWriteBack & ~moduleIn.isMemWrite;
      moduleOut.wbData      <= w_wb_data;
      moduleOut.instrAddr   <= moduleIn.instrAddr;
      moduleOut.instr       <= moduleIn.instr;
      moduleOut.memAddr     <= moduleIn.aluOut;
      moduleOut.isMem       <= moduleIn.isMemRead | moduleIn.isMemWrite;
      moduleOut.misalign    <= w_misalign;
    end
  end

endmodule
